// File: rtl/axi_lite_arbiter.sv
// Two-requester AXI-lite arbiter sharing one downstream slave; read and write paths are arbitrated independently.
// Define AXI_LITE_ARB_FIXED_PRIO_EN for fixed m0 priority instead of round-robin.
module axi_lite_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic [ADDR_W-1:0]   m0_axi_awaddr,
   input  logic [2:0]          m0_axi_awprot,
   input  logic                m0_axi_awvalid,
   output logic                m0_axi_awready,
   input  logic [DATA_W-1:0]   m0_axi_wdata,
   input  logic [DATA_W/8-1:0] m0_axi_wstrb,
   input  logic                m0_axi_wvalid,
   output logic                m0_axi_wready,
   output logic [1:0]          m0_axi_bresp,
   output logic                m0_axi_bvalid,
   input  logic                m0_axi_bready,
   input  logic [ADDR_W-1:0]   m0_axi_araddr,
   input  logic [2:0]          m0_axi_arprot,
   input  logic                m0_axi_arvalid,
   output logic                m0_axi_arready,
   output logic [DATA_W-1:0]   m0_axi_rdata,
   output logic [1:0]          m0_axi_rresp,
   output logic                m0_axi_rvalid,
   input  logic                m0_axi_rready,
   input  logic [ADDR_W-1:0]   m1_axi_awaddr,
   input  logic [2:0]          m1_axi_awprot,
   input  logic                m1_axi_awvalid,
   output logic                m1_axi_awready,
   input  logic [DATA_W-1:0]   m1_axi_wdata,
   input  logic [DATA_W/8-1:0] m1_axi_wstrb,
   input  logic                m1_axi_wvalid,
   output logic                m1_axi_wready,
   output logic [1:0]          m1_axi_bresp,
   output logic                m1_axi_bvalid,
   input  logic                m1_axi_bready,
   input  logic [ADDR_W-1:0]   m1_axi_araddr,
   input  logic [2:0]          m1_axi_arprot,
   input  logic                m1_axi_arvalid,
   output logic                m1_axi_arready,
   output logic [DATA_W-1:0]   m1_axi_rdata,
   output logic [1:0]          m1_axi_rresp,
   output logic                m1_axi_rvalid,
   input  logic                m1_axi_rready,
   output logic [ADDR_W-1:0]   s_axi_awaddr,
   output logic [2:0]          s_axi_awprot,
   output logic                s_axi_awvalid,
   input  logic                s_axi_awready,
   output logic [DATA_W-1:0]   s_axi_wdata,
   output logic [DATA_W/8-1:0] s_axi_wstrb,
   output logic                s_axi_wvalid,
   input  logic                s_axi_wready,
   input  logic [1:0]          s_axi_bresp,
   input  logic                s_axi_bvalid,
   output logic                s_axi_bready,
   output logic [ADDR_W-1:0]   s_axi_araddr,
   output logic [2:0]          s_axi_arprot,
   output logic                s_axi_arvalid,
   input  logic                s_axi_arready,
   input  logic [DATA_W-1:0]   s_axi_rdata,
   input  logic [1:0]          s_axi_rresp,
   input  logic                s_axi_rvalid,
   output logic                s_axi_rready
);

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;

   r_state_t r_state, r_state_next;
   w_state_t w_state, w_state_next;
   logic     r_gnt, r_gnt_next, r_pick;
   logic     w_gnt, w_gnt_next, w_pick;
   logic     aw_done, aw_done_next, w_done, w_done_next;
   logic     gnt_arvalid, gnt_awvalid, gnt_wvalid, aw_hs, w_hs;

   // Response payloads go to both requesters; only the grantee ever sees valid.
   assign m0_axi_rdata = s_axi_rdata;
   assign m1_axi_rdata = s_axi_rdata;
   assign m0_axi_rresp = s_axi_rresp;
   assign m1_axi_rresp = s_axi_rresp;
   assign m0_axi_bresp = s_axi_bresp;
   assign m1_axi_bresp = s_axi_bresp;

   assign s_axi_araddr = r_gnt ? m1_axi_araddr : m0_axi_araddr;
   assign s_axi_arprot = r_gnt ? m1_axi_arprot : m0_axi_arprot;
   assign s_axi_awaddr = w_gnt ? m1_axi_awaddr : m0_axi_awaddr;
   assign s_axi_awprot = w_gnt ? m1_axi_awprot : m0_axi_awprot;
   assign s_axi_wdata  = w_gnt ? m1_axi_wdata  : m0_axi_wdata;
   assign s_axi_wstrb  = w_gnt ? m1_axi_wstrb  : m0_axi_wstrb;
   assign gnt_arvalid  = r_gnt ? m1_axi_arvalid : m0_axi_arvalid;
   assign gnt_awvalid  = w_gnt ? m1_axi_awvalid : m0_axi_awvalid;
   assign gnt_wvalid   = w_gnt ? m1_axi_wvalid  : m0_axi_wvalid;

`ifdef AXI_LITE_ARB_FIXED_PRIO_EN
   assign r_pick = ~m0_axi_arvalid;
   assign w_pick = ~m0_axi_awvalid;
`else
   logic r_last, w_last;

   // Last-grant bits move only when a transaction fully completes, so an abandoned one never skews fairness.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_last <= 1'b1;
         w_last <= 1'b1;
      end else begin
         if (r_state == R_DATA && s_axi_rvalid && s_axi_rready)
            r_last <= r_gnt;
         if (w_state == W_RESP && s_axi_bvalid && s_axi_bready)
            w_last <= w_gnt;
      end
   end

   assign r_pick = (m0_axi_arvalid && m1_axi_arvalid) ? ~r_last : ~m0_axi_arvalid;
   assign w_pick = (m0_axi_awvalid && m1_axi_awvalid) ? ~w_last : ~m0_axi_awvalid;
`endif

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state <= R_IDLE;
         r_gnt   <= 1'b0;
         w_state <= W_IDLE;
         w_gnt   <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         r_state <= r_state_next;
         r_gnt   <= r_gnt_next;
         w_state <= w_state_next;
         w_gnt   <= w_gnt_next;
         aw_done <= aw_done_next;
         w_done  <= w_done_next;
      end
   end

   always_comb begin
      r_state_next   = r_state;
      r_gnt_next     = r_gnt;
      s_axi_arvalid  = 1'b0;
      s_axi_rready   = 1'b0;
      m0_axi_arready = 1'b0;
      m1_axi_arready = 1'b0;
      m0_axi_rvalid  = 1'b0;
      m1_axi_rvalid  = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (m0_axi_arvalid || m1_axi_arvalid) begin
               r_gnt_next   = r_pick;
               r_state_next = R_ADDR;
            end
         end
         R_ADDR: begin
            s_axi_arvalid  = gnt_arvalid;
            m0_axi_arready = ~r_gnt & s_axi_arready;
            m1_axi_arready = r_gnt & s_axi_arready;
            if (gnt_arvalid && s_axi_arready)
               r_state_next = R_DATA;
         end
         R_DATA: begin
            m0_axi_rvalid = ~r_gnt & s_axi_rvalid;
            m1_axi_rvalid = r_gnt & s_axi_rvalid;
            s_axi_rready  = r_gnt ? m1_axi_rready : m0_axi_rready;
            if (s_axi_rvalid && s_axi_rready)
               r_state_next = R_IDLE;
         end
         default: r_state_next = R_IDLE;
      endcase
   end

   // AW and W are forwarded together; each done flag masks its channel once it has handshaken.
   always_comb begin
      w_state_next   = w_state;
      w_gnt_next     = w_gnt;
      aw_done_next   = aw_done;
      w_done_next    = w_done;
      aw_hs          = 1'b0;
      w_hs           = 1'b0;
      s_axi_awvalid  = 1'b0;
      s_axi_wvalid   = 1'b0;
      s_axi_bready   = 1'b0;
      m0_axi_awready = 1'b0;
      m1_axi_awready = 1'b0;
      m0_axi_wready  = 1'b0;
      m1_axi_wready  = 1'b0;
      m0_axi_bvalid  = 1'b0;
      m1_axi_bvalid  = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (m0_axi_awvalid || m1_axi_awvalid) begin
               w_gnt_next   = w_pick;
               w_state_next = W_REQ;
            end
         end
         W_REQ: begin
            s_axi_awvalid  = gnt_awvalid & ~aw_done;
            s_axi_wvalid   = gnt_wvalid & ~w_done;
            m0_axi_awready = ~w_gnt & ~aw_done & s_axi_awready;
            m1_axi_awready = w_gnt & ~aw_done & s_axi_awready;
            m0_axi_wready  = ~w_gnt & ~w_done & s_axi_wready;
            m1_axi_wready  = w_gnt & ~w_done & s_axi_wready;
            aw_hs          = gnt_awvalid & ~aw_done & s_axi_awready;
            w_hs           = gnt_wvalid & ~w_done & s_axi_wready;
            aw_done_next   = aw_done | aw_hs;
            w_done_next    = w_done | w_hs;
            if (aw_done_next && w_done_next)
               w_state_next = W_RESP;
         end
         W_RESP: begin
            m0_axi_bvalid = ~w_gnt & s_axi_bvalid;
            m1_axi_bvalid = w_gnt & s_axi_bvalid;
            s_axi_bready  = w_gnt ? m1_axi_bready : m0_axi_bready;
            if (s_axi_bvalid && s_axi_bready) begin
               aw_done_next = 1'b0;
               w_done_next  = 1'b0;
               w_state_next = W_IDLE;
            end
         end
         default: w_state_next = W_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Self-checking bench for axi_lite_arbiter: directed vector table, hand-written corner sequences,
// and random transactions scored against a last-winner arbitration model.
module tb_axi_lite_arbiter;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;
   localparam logic [31:0] ADDR0_R = 32'h0001_0004;
   localparam logic [31:0] ADDR1_R = 32'h0002_0008;
   localparam logic [31:0] ADDR0_W = 32'h0003_0010;
   localparam logic [31:0] ADDR1_W = 32'h0004_0020;
   localparam logic [31:0] WDATA0  = 32'hA5A5_0000;
   localparam logic [31:0] WDATA1  = 32'h5A5A_1111;
`ifdef AXI_LITE_ARB_FIXED_PRIO_EN
   localparam bit FP = 1'b1;
`else
   localparam bit FP = 1'b0;
`endif

   logic aclk = 1'b0;
   logic aresetn;
   always #5 aclk = ~aclk;

   logic [ADDR_W-1:0] m0_axi_awaddr, m1_axi_awaddr, m0_axi_araddr, m1_axi_araddr, s_axi_awaddr, s_axi_araddr;
   logic [2:0]        m0_axi_awprot, m1_axi_awprot, m0_axi_arprot, m1_axi_arprot, s_axi_awprot, s_axi_arprot;
   logic [DATA_W-1:0] m0_axi_wdata, m1_axi_wdata, s_axi_wdata, m0_axi_rdata, m1_axi_rdata, s_axi_rdata;
   logic [STRB_W-1:0] m0_axi_wstrb, m1_axi_wstrb, s_axi_wstrb;
   logic [1:0]        m0_axi_bresp, m1_axi_bresp, s_axi_bresp, m0_axi_rresp, m1_axi_rresp, s_axi_rresp;
   logic m0_axi_awvalid, m0_axi_awready, m0_axi_wvalid, m0_axi_wready, m0_axi_bvalid, m0_axi_bready;
   logic m0_axi_arvalid, m0_axi_arready, m0_axi_rvalid, m0_axi_rready;
   logic m1_axi_awvalid, m1_axi_awready, m1_axi_wvalid, m1_axi_wready, m1_axi_bvalid, m1_axi_bready;
   logic m1_axi_arvalid, m1_axi_arready, m1_axi_rvalid, m1_axi_rready;
   logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;
   logic s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;

   axi_lite_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .m0_axi_awaddr(m0_axi_awaddr), .m0_axi_awprot(m0_axi_awprot), .m0_axi_awvalid(m0_axi_awvalid), .m0_axi_awready(m0_axi_awready),
      .m0_axi_wdata(m0_axi_wdata), .m0_axi_wstrb(m0_axi_wstrb), .m0_axi_wvalid(m0_axi_wvalid), .m0_axi_wready(m0_axi_wready),
      .m0_axi_bresp(m0_axi_bresp), .m0_axi_bvalid(m0_axi_bvalid), .m0_axi_bready(m0_axi_bready),
      .m0_axi_araddr(m0_axi_araddr), .m0_axi_arprot(m0_axi_arprot), .m0_axi_arvalid(m0_axi_arvalid), .m0_axi_arready(m0_axi_arready),
      .m0_axi_rdata(m0_axi_rdata), .m0_axi_rresp(m0_axi_rresp), .m0_axi_rvalid(m0_axi_rvalid), .m0_axi_rready(m0_axi_rready),
      .m1_axi_awaddr(m1_axi_awaddr), .m1_axi_awprot(m1_axi_awprot), .m1_axi_awvalid(m1_axi_awvalid), .m1_axi_awready(m1_axi_awready),
      .m1_axi_wdata(m1_axi_wdata), .m1_axi_wstrb(m1_axi_wstrb), .m1_axi_wvalid(m1_axi_wvalid), .m1_axi_wready(m1_axi_wready),
      .m1_axi_bresp(m1_axi_bresp), .m1_axi_bvalid(m1_axi_bvalid), .m1_axi_bready(m1_axi_bready),
      .m1_axi_araddr(m1_axi_araddr), .m1_axi_arprot(m1_axi_arprot), .m1_axi_arvalid(m1_axi_arvalid), .m1_axi_arready(m1_axi_arready),
      .m1_axi_rdata(m1_axi_rdata), .m1_axi_rresp(m1_axi_rresp), .m1_axi_rvalid(m1_axi_rvalid), .m1_axi_rready(m1_axi_rready),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
   );

   typedef struct {
      bit isWrite;
      bit req0;
      bit req1;
      int wDelay;
      int expWinner;
   } vec_t;

   int errors = 0;
   int checks = 0;
   int modelLast[2];

   // Arbitration rule: sole requester wins; on contention the one that did not win last time (or m0 when fixed).
   function automatic int modelWinner(input int path, input bit r0, input bit r1);
      if (r0 && r1)
         return FP ? 0 : 1 - modelLast[path];
      return r0 ? 0 : 1;
   endfunction

   function automatic logic [14:0] allValidReady();
      return {s_axi_arvalid, s_axi_rready, s_axi_awvalid, s_axi_wvalid, s_axi_bready,
              m0_axi_arready, m1_axi_arready, m0_axi_rvalid, m1_axi_rvalid,
              m0_axi_awready, m1_axi_awready, m0_axi_wready, m1_axi_wready,
              m0_axi_bvalid, m1_axi_bvalid};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
      end
   endtask

   task automatic idleInputs();
      {m0_axi_awvalid, m0_axi_wvalid, m0_axi_bready, m0_axi_arvalid, m0_axi_rready} = '0;
      {m1_axi_awvalid, m1_axi_wvalid, m1_axi_bready, m1_axi_arvalid, m1_axi_rready} = '0;
      {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid} = '0;
      m0_axi_awaddr = ADDR0_W; m1_axi_awaddr = ADDR1_W;
      m0_axi_araddr = ADDR0_R; m1_axi_araddr = ADDR1_R;
      m0_axi_awprot = 3'd1; m1_axi_awprot = 3'd2;
      m0_axi_arprot = 3'd1; m1_axi_arprot = 3'd2;
      m0_axi_wdata = WDATA0; m1_axi_wdata = WDATA1;
      m0_axi_wstrb = 4'h3; m1_axi_wstrb = 4'hC;
      s_axi_bresp = 2'b00; s_axi_rresp = 2'b00; s_axi_rdata = '0;
   endtask

   task automatic resetDut();
      @(negedge aclk);
      aresetn = 1'b0;
      idleInputs();
      repeat (2) @(negedge aclk);
      #1 checkOutput("reset_outputs", allValidReady(), 15'h0);
      aresetn = 1'b1;
      modelLast[0] = 1;
      modelLast[1] = 1;
   endtask

   task automatic doRead(input bit r0, input bit r1, input logic [31:0] data, output int winner);
      int w;
      @(negedge aclk);
      m0_axi_arvalid = r0;
      m1_axi_arvalid = r1;
      #1 checkOutput("ar_idle_before_grant", s_axi_arvalid, 1'b0);
      @(negedge aclk);
      checkOutput("ar_valid_latency1", s_axi_arvalid, 1'b1);
      if (s_axi_araddr == ADDR0_R) w = 0;
      else if (s_axi_araddr == ADDR1_R) w = 1;
      else begin
         w = 0;
         checkOutput("ar_addr_known", s_axi_araddr, ADDR0_R);
      end
      checkOutput("ar_prot", s_axi_arprot, (w == 1) ? 3'd2 : 3'd1);
      s_axi_arready = 1'b1;
      #1 checkOutput("arready_grantee", (w == 1) ? m1_axi_arready : m0_axi_arready, 1'b1);
      checkOutput("arready_other", (w == 1) ? m0_axi_arready : m1_axi_arready, 1'b0);
      @(negedge aclk);
      s_axi_arready = 1'b0;
      if (w == 1) m1_axi_arvalid = 1'b0; else m0_axi_arvalid = 1'b0;
      m0_axi_rready = (w == 0);
      m1_axi_rready = (w == 1);
      s_axi_rvalid = 1'b1;
      s_axi_rdata = data;
      #1 checkOutput("ar_dropped_in_data", s_axi_arvalid, 1'b0);
      checkOutput("rvalid_grantee", (w == 1) ? m1_axi_rvalid : m0_axi_rvalid, 1'b1);
      checkOutput("rvalid_other", (w == 1) ? m0_axi_rvalid : m1_axi_rvalid, 1'b0);
      checkOutput("rdata_grantee", (w == 1) ? m1_axi_rdata : m0_axi_rdata, data);
      checkOutput("s_rready_forward", s_axi_rready, 1'b1);
      @(negedge aclk);
      s_axi_rvalid = 1'b0;
      {m0_axi_arvalid, m1_axi_arvalid, m0_axi_rready, m1_axi_rready} = '0;
      #1 checkOutput("read_back_idle", allValidReady(), 15'h0);
      winner = w;
   endtask

   task automatic doWrite(input bit r0, input bit r1, input int d, input logic [1:0] bresp, output int winner);
      int w;
      int wEnd;
      wEnd = (d < 1) ? 1 : d;
      @(negedge aclk);
      m0_axi_awvalid = r0;
      m1_axi_awvalid = r1;
      m0_axi_wvalid = r0 && (d == 0);
      m1_axi_wvalid = r1 && (d == 0);
      #1 checkOutput("aw_idle_before_grant", s_axi_awvalid, 1'b0);
      @(negedge aclk);
      checkOutput("aw_valid_latency1", s_axi_awvalid, 1'b1);
      if (s_axi_awaddr == ADDR0_W) w = 0;
      else if (s_axi_awaddr == ADDR1_W) w = 1;
      else begin
         w = 0;
         checkOutput("aw_addr_known", s_axi_awaddr, ADDR0_W);
      end
      s_axi_awready = 1'b1;
      s_axi_wready = 1'b1;
      if (d == 1) begin
         if (w == 1) m1_axi_wvalid = 1'b1; else m0_axi_wvalid = 1'b1;
      end
      #1 checkOutput("awready_grantee", (w == 1) ? m1_axi_awready : m0_axi_awready, 1'b1);
      checkOutput("awready_other", (w == 1) ? m0_axi_awready : m1_axi_awready, 1'b0);
      checkOutput("wready_other", (w == 1) ? m0_axi_wready : m1_axi_wready, 1'b0);
      checkOutput("no_resp_in_wreq", s_axi_bready, 1'b0);
      for (int k = 2; k <= d; k++) begin
         @(negedge aclk);
         if (w == 1) m1_axi_awvalid = 1'b0; else m0_axi_awvalid = 1'b0;
         if (k == d) begin
            if (w == 1) m1_axi_wvalid = 1'b1; else m0_axi_wvalid = 1'b1;
         end
         #1 checkOutput("aw_masked_after_hs", s_axi_awvalid, 1'b0);
         checkOutput("no_resp_before_w", s_axi_bready, 1'b0);
         checkOutput("wvalid_only_when_driven", s_axi_wvalid, k == d);
      end
      if (wEnd == 1) checkOutput("wdata_fwd", s_axi_wdata, (w == 1) ? WDATA1 : WDATA0);
      @(negedge aclk);
      {m0_axi_awvalid, m1_axi_awvalid, m0_axi_wvalid, m1_axi_wvalid} = '0;
      s_axi_awready = 1'b0;
      s_axi_wready = 1'b0;
      m0_axi_bready = (w == 0);
      m1_axi_bready = (w == 1);
      s_axi_bvalid = 1'b1;
      s_axi_bresp = bresp;
      #1 checkOutput("s_bready_in_resp", s_axi_bready, 1'b1);
      checkOutput("bvalid_grantee", (w == 1) ? m1_axi_bvalid : m0_axi_bvalid, 1'b1);
      checkOutput("bvalid_other", (w == 1) ? m0_axi_bvalid : m1_axi_bvalid, 1'b0);
      checkOutput("bresp_grantee", (w == 1) ? m1_axi_bresp : m0_axi_bresp, bresp);
      @(negedge aclk);
      s_axi_bvalid = 1'b0;
      m0_axi_bready = 1'b0;
      m1_axi_bready = 1'b0;
      #1 checkOutput("write_back_idle", allValidReady(), 15'h0);
      winner = w;
   endtask

   task automatic applyStimulus(input vec_t v, output int winner);
      if (v.isWrite)
         doWrite(v.req0, v.req1, v.wDelay, 2'b00, winner);
      else
         doRead(v.req0, v.req1, $urandom, winner);
   endtask

   initial begin
      vec_t vecs[11];
      int w;
      int pick;
      int path;
      int expW;
      bit isW;
      logic [31:0] rdata;

      // Expected grantees from reset with both last-grant bits pointing at m1.
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 0, 0};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 0, FP ? 0 : 1};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 0, 0};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 0, FP ? 0 : 1};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 0, 1};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 0, 0};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 3, 0};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 0, FP ? 0 : 1};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 1, 1};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 2, 0};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 0, FP ? 0 : 1};

      aresetn = 1'b0;
      idleInputs();
      resetDut();

      doRead(1'b1, 1'b0, 32'hDEAD_BEEF, w);
      checkOutput("single_read_winner", w, 0);

      resetDut();
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i], w);
         checkOutput($sformatf("vec%0d_winner", i), w, vecs[i].expWinner);
         modelLast[vecs[i].isWrite ? 1 : 0] = vecs[i].expWinner;
      end

      // Read on m0 and write on m1 in flight together.
      @(negedge aclk);
      m0_axi_arvalid = 1'b1;
      m1_axi_awvalid = 1'b1;
      m1_axi_wvalid = 1'b1;
      @(negedge aclk);
      checkOutput("concurrent_ar_aw", {s_axi_arvalid, s_axi_awvalid, s_axi_wvalid}, 3'b111);
      s_axi_arready = 1'b1;
      s_axi_awready = 1'b1;
      s_axi_wready = 1'b1;
      @(negedge aclk);
      {m0_axi_arvalid, m1_axi_awvalid, m1_axi_wvalid, s_axi_arready, s_axi_awready, s_axi_wready} = '0;
      m0_axi_rready = 1'b1;
      m1_axi_bready = 1'b1;
      s_axi_rvalid = 1'b1;
      s_axi_rdata = 32'h1234_5678;
      s_axi_bvalid = 1'b1;
      s_axi_bresp = 2'b01;
      #1 checkOutput("concurrent_resp", {m0_axi_rvalid, m1_axi_bvalid, m1_axi_rvalid, m0_axi_bvalid}, 4'b1100);
      checkOutput("concurrent_rdata", m0_axi_rdata, 32'h1234_5678);
      checkOutput("concurrent_bresp", m1_axi_bresp, 2'b01);
      @(negedge aclk);
      {s_axi_rvalid, s_axi_bvalid, m0_axi_rready, m1_axi_bready} = '0;
      #1 checkOutput("concurrent_idle", allValidReady(), 15'h0);
      modelLast[0] = 0;
      modelLast[1] = 1;

      // m0 completes a read, then an m1 read is cut off by reset while rvalid is high.
      doRead(1'b1, 1'b0, $urandom, w);
      checkOutput("pre_reset_read_winner", w, 0);
      modelLast[0] = 0;
      @(negedge aclk);
      m1_axi_arvalid = 1'b1;
      @(negedge aclk);
      s_axi_arready = 1'b1;
      @(negedge aclk);
      m1_axi_arvalid = 1'b0;
      s_axi_arready = 1'b0;
      s_axi_rvalid = 1'b1;
      #1 checkOutput("m1_in_rdata", m1_axi_rvalid, 1'b1);
      aresetn = 1'b0;
      @(negedge aclk);
      #1 checkOutput("reset_mid_read", allValidReady(), 15'h0);
      aresetn = 1'b1;
      s_axi_rvalid = 1'b0;
      modelLast[0] = 1;
      modelLast[1] = 1;
      doRead(1'b1, 1'b1, $urandom, w);
      checkOutput("post_reset_contention", w, modelWinner(0, 1'b1, 1'b1));
      modelLast[0] = 0;

      for (int i = 0; i < 30; i++) begin
         isW = 1'($urandom_range(0, 1));
         pick = $urandom_range(1, 3);
         path = isW ? 1 : 0;
         expW = modelWinner(path, pick[0], pick[1]);
         if (isW)
            doWrite(pick[0], pick[1], $urandom_range(0, 3), 2'($urandom_range(0, 3)), w);
         else begin
            rdata = $urandom;
            doRead(pick[0], pick[1], rdata, w);
         end
         checkOutput($sformatf("rand%0d_winner", i), w, expW);
         modelLast[path] = expW;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width of all AR/AW buses.
REQ-002 SHALL have parameter DATA_W, default 32: data width; strobe width is DATA_W/8.
REQ-003 SHALL have port aclk, input, 1: clock; all logic on rising edge.
REQ-004 SHALL have port aresetn, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have ports m{0,1}_axi_awaddr/awprot/awvalid, input, ADDR_W/3/1: requester write address.
REQ-006 SHALL have port m{0,1}_axi_awready, output, 1: write address accept.
REQ-007 SHALL have ports m{0,1}_axi_wdata/wstrb/wvalid, input, DATA_W/DATA_W/8/1, plus m{0,1}_axi_wready, output, 1: write data.
REQ-008 SHALL have ports m{0,1}_axi_bresp/bvalid, output, 2/1, plus m{0,1}_axi_bready, input, 1: write response.
REQ-009 SHALL have ports m{0,1}_axi_araddr/arprot/arvalid, input, ADDR_W/3/1, plus m{0,1}_axi_arready, output, 1: read address.
REQ-010 SHALL have ports m{0,1}_axi_rdata/rresp/rvalid, output, DATA_W/2/1, plus m{0,1}_axi_rready, input, 1: read data.
REQ-011 SHALL have ports s_axi_* mirroring REQ-005..010 with directions inverted: single shared downstream AXI-lite slave port.

Function
REQ-012 SHALL arbitrate read and write paths independently; one outstanding transaction per path.
REQ-013 Read FSM SHALL have states R_IDLE, R_ADDR, R_DATA.
REQ-014 In R_IDLE with any m*_axi_arvalid=1, SHALL register the grant and enter R_ADDR next cycle; s_axi_arvalid asserts one cycle after request (latency 1).
REQ-015 In R_ADDR SHALL forward granted araddr/arprot/arvalid to s_axi and s_axi_arready to granted arready combinationally; on s_axi_arvalid&s_axi_arready SHALL enter R_DATA.
REQ-016 In R_DATA SHALL forward s_axi_rdata/rresp/rvalid to granted requester and its rready to s_axi_rready; on rvalid&rready SHALL return to R_IDLE.
REQ-017 Write FSM SHALL have states W_IDLE, W_REQ, W_RESP.
REQ-018 In W_IDLE, grant SHALL be taken when either requester has awvalid=1; enter W_REQ next cycle.
REQ-019 In W_REQ SHALL forward AW and W channels of grantee concurrently, tracking aw_done and w_done flags; enter W_RESP when both handshakes completed (same or different cycles).
REQ-020 In W_RESP SHALL forward B channel; on bvalid&bready SHALL clear flags and return to W_IDLE.
REQ-021 Non-granted requester SHALL see arready/awready/wready=0 and rvalid/bvalid=0 at all times.
REQ-022 In *_IDLE all s_axi valid/ready outputs and all requester ready/valid outputs SHALL be 0.
REQ-023 Round-robin: each path keeps a last-grant bit; on simultaneous requests grant goes to the requester not last granted; sole requester always wins.
REQ-024 Last-grant bit SHALL update only on completion (R or B handshake).
REQ-025 Requester dropping valid in R_ADDR/W_REQ is a protocol violation; behaviour is not required beyond FSM not hanging past next downstream handshake.

Reset
REQ-026 aresetn=0 SHALL force R_IDLE, W_IDLE, aw_done=w_done=0, last-grant bits=1 (so m0 wins first contention).
REQ-027 Reset mid-transaction SHALL abandon the transaction; all valid/ready outputs 0 in the cycle following the reset edge.

Configuration
REQ-028 Macro AXI_LITE_ARB_FIXED_PRIO_EN defined: m0 SHALL always win simultaneous requests on both paths; last-grant bits absent.
REQ-029 Macro undefined: round-robin per REQ-023.

Verification
REQ-030 Single read: m0 araddr=0x0001_0004, slave rdata=0xDEAD_BEEF -> s_axi_arvalid 1 cycle after m0 arvalid, m0 rdata=0xDEAD_BEEF, m1 rvalid stays 0.
REQ-031 Simultaneous reads from m0 and m1 held 4 transactions -> grant order m0,m1,m0,m1 (fixed-prio build: m0 x4, m1 starved).
REQ-032 Write with wvalid 3 cycles after awvalid, slave bresp=2'b00 -> W_RESP entered only after both handshakes, grantee bresp=0, bvalid pulse once.
REQ-033 Concurrent m0 read and m1 write -> both complete without mutual blocking; s_axi AR and AW may be valid same cycle.
REQ-034 aresetn=0 asserted in R_DATA with s_axi_rvalid=1 -> next cycle all ready/valid outputs 0, next m1 vs m0 contention granted m0.
